// File: rtl/arb4_32_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : arb4_pkg                                                     |
// | Purpose : Shared constants, FSM state encoding and the round-robin     |
// |           search helper for the 4-requester arbiter.                   |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package arb4_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Returns {found, index}. The search starts at ptr and walks upward with
    // wrap-around; the loop runs high-to-low so the nearest hit is written last.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NREQ-1:0]  r,
        input logic [IDX_W-1:0] p
    );
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] c;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = p + IDX_W'(k);
            if (r[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb4_32_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : MUX4T1_32                                                    |
// | Purpose : 4-to-1 data multiplexer selecting one W-bit word.            |
// | Ports   : sel_i [1:0]     - word select                                |
// |           d0_i..d3_i [W]  - candidate words                            |
// |           y_o [W]         - selected word                              |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module MUX4T1_32 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/arb4_32.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : arb4_32                                                      |
// | Purpose : 4-requester round-robin arbiter with registered one-hot      |
// |           grant, valid/ready hand-off and back-to-back re-arbitration. |
// | Ports   : clk, rst (sync, active-high)                                 |
// |           req[3:0], I0..I3[W], o_ready  - requests, data, downstream   |
// |           lock[3:0] (ARB4_LOCK_EN only) - per-requester burst lock     |
// |           grant[3:0], s[1:0], o_valid   - registered grant outputs     |
// |           o[W], ack[3:0]                - combinational data / ack     |
// | Config  : define ARB4_LOCK_EN to add the lock input and burst hold.    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module arb4_32
    import arb4_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [W-1:0]      I0,
    input  logic [W-1:0]      I1,
    input  logic [W-1:0]      I2,
    input  logic [W-1:0]      I3,
    input  logic              o_ready,
`ifdef ARB4_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   grant,
    output logic [IDX_W-1:0]  s,
    output logic [W-1:0]      o,
    output logic              o_valid,
    output logic [NREQ-1:0]   ack
);

    state_e               state_q, state_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]     s_q, s_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 valid_q, valid_d;

    logic                 xfer;
    logic                 lock_hold;
    logic [IDX_W-1:0]     ptr_adv;
    logic [IDX_W:0]       pick_idle;
    logic [IDX_W:0]       pick_next;

    assign xfer    = valid_q & o_ready;
    assign ptr_adv = s_q + IDX_W'(1);

`ifdef ARB4_LOCK_EN
    assign lock_hold = lock[s_q];
`else
    assign lock_hold = 1'b0;
`endif

    // From IDLE search from ptr; after a transfer search from just past the
    // served requester so it naturally ends up lowest priority.
    assign pick_idle = rr_pick(req, ptr_q);
    assign pick_next = rr_pick(req, ptr_adv);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_idle[IDX_W]) begin
                    state_d = GRANT;
                    s_d     = pick_idle[IDX_W-1:0];
                    grant_d = NREQ'(1) << pick_idle[IDX_W-1:0];
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (!lock_hold) begin
                        ptr_d = ptr_adv;
                        if (pick_next[IDX_W]) begin
                            s_d     = pick_next[IDX_W-1:0];
                            grant_d = NREQ'(1) << pick_next[IDX_W-1:0];
                        end else begin
                            state_d = IDLE;
                            s_d     = '0;
                            grant_d = '0;
                            valid_d = 1'b0;
                        end
                    end
                end else if (!req[s_q]) begin
                    // Requester withdrew before being served: release quietly.
                    state_d = IDLE;
                    s_d     = '0;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            s_q     <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    MUX4T1_32 #(
        .W (W)
    ) u_mux (
        .sel_i (s_q),
        .d0_i  (I0),
        .d1_i  (I1),
        .d2_i  (I2),
        .d3_i  (I3),
        .y_o   (o)
    );

    assign grant   = grant_q;
    assign s       = s_q;
    assign o_valid = valid_q;
    // Reset wins over a pending hand-off, so no ack escapes in the reset cycle.
    assign ack     = grant_q & {NREQ{valid_q & o_ready & ~rst}};

endmodule
`default_nettype wire

// File: tb/tb_arb4_32.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_arb4_32                                                   |
// | Purpose : Self-checking bench for arb4_32; expected winners are queued |
// |           when requests are driven and popped when an ack appears.     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_arb4_32;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] I0, I1, I2, I3;
    logic        o_ready;
`ifdef ARB4_LOCK_EN
    logic [3:0]  lock;
`endif
    wire  [3:0]  grant;
    wire  [1:0]  s;
    wire  [31:0] o;
    wire         o_valid;
    wire  [3:0]  ack;

    int n_cmp = 0;
    int n_err = 0;
    int sb[$];
    int exp_idx;

    always #5 clk = ~clk;

    arb4_32 #(.W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .I0      (I0),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .o_ready (o_ready),
`ifdef ARB4_LOCK_EN
        .lock    (lock),
`endif
        .grant   (grant),
        .s       (s),
        .o       (o),
        .o_valid (o_valid),
        .ack     (ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0; o_ready = 1'b0;
`ifdef ARB4_LOCK_EN
        lock = 4'b0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; o_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
            n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
            n_cmp++; if (s !== 2'd0) begin n_err++; $display("FAIL reset_s: got %0d want 0", s); end
            n_cmp++; if (ack !== 4'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ack); end
            n_cmp++; if (o !== I0) begin n_err++; $display("FAIL reset_o: got %h want %h", o, I0); end
        end
        rst = 1'b0; req = 4'b0; o_ready = 1'b0;
        step();
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b1111; o_ready = 1'b1;
        sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 4) req = 4'b0;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++; $display("FAIL rot_sb: got ack %b with empty queue", ack);
            end else begin
                exp_idx = sb.pop_front();
                if (ack !== (4'b0001 << exp_idx) || o !== 32'(exp_idx)) begin
                    n_err++;
                    $display("FAIL rot_%0d: got ack %b o %h want ack %b o %h", k, ack, o, 4'b0001 << exp_idx, 32'(exp_idx));
                end
            end
        end
        step();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rot_idle: got valid %b want 0", o_valid); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; o_ready = 1'b1;
        sb.push_back(2);
        step();
        n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", grant); end
        n_cmp++; if (s !== 2'd2) begin n_err++; $display("FAIL single_s: got %0d want 2", s); end
        n_cmp++; if (o !== 32'h2) begin n_err++; $display("FAIL single_o: got %h want 00000002", o); end
        exp_idx = (sb.size() != 0) ? sb.pop_front() : -1;
        n_cmp++; if (ack !== (4'b0001 << exp_idx)) begin n_err++; $display("FAIL single_ack: got %b want idx %0d", ack, exp_idx); end
        // Pointer should now be 3, so with everyone requesting I3 wins next.
        req = 4'b1111;
        sb.push_back(3);
        step();
        exp_idx = (sb.size() != 0) ? sb.pop_front() : -1;
        n_cmp++; if (ack !== (4'b0001 << exp_idx)) begin n_err++; $display("FAIL single_ptr3: got ack %b want idx %0d", ack, exp_idx); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0011; o_ready = 1'b0;
        sb.push_back(0); sb.push_back(1);
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (grant !== 4'b0001 || ack !== 4'b0) begin
                n_err++; $display("FAIL bp_hold_%0d: got grant %b ack %b want 0001 0000", c, grant, ack);
            end
        end
        o_ready = 1'b1;
        #1;
        exp_idx = (sb.size() != 0) ? sb.pop_front() : -1;
        n_cmp++; if (ack !== (4'b0001 << exp_idx)) begin n_err++; $display("FAIL bp_ack0: got %b want idx %0d", ack, exp_idx); end
        step();
        req = 4'b0;
        exp_idx = (sb.size() != 0) ? sb.pop_front() : -1;
        n_cmp++; if (grant !== 4'b0010 || ack !== (4'b0001 << exp_idx)) begin
            n_err++; $display("FAIL bp_next: got grant %b ack %b want 0010 idx %0d", grant, ack, exp_idx);
        end
    endtask

    task automatic test_withdrawal();
        do_reset();
        req = 4'b1000; o_ready = 1'b0;
        step();
        n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL wd_grant: got %b want 1000", grant); end
        req = 4'b0000;
        #1;
        n_cmp++; if (ack !== 4'b0) begin n_err++; $display("FAIL wd_noack: got %b want 0000", ack); end
        step();
        n_cmp++; if (o_valid !== 1'b0 || grant !== 4'b0 || ack !== 4'b0) begin
            n_err++; $display("FAIL wd_drop: got valid %b grant %b ack %b want 0 0000 0000", o_valid, grant, ack);
        end
        // Pointer untouched (still 0): requester 0 wins from a full request.
        req = 4'b1111; o_ready = 1'b1;
        step();
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL wd_ptr: got %b want 0001", grant); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        req = 4'b0010; o_ready = 1'b0;
        step();
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL rif_grant: got %b want 0010", grant); end
        rst = 1'b1; o_ready = 1'b1;
        #1;
        n_cmp++; if (ack !== 4'b0) begin n_err++; $display("FAIL rif_ack: got %b want 0000", ack); end
        step();
        n_cmp++; if (grant !== 4'b0 || o_valid !== 1'b0) begin
            n_err++; $display("FAIL rif_clear: got grant %b valid %b want 0000 0", grant, o_valid);
        end
        rst = 1'b0; req = 4'b0;
    endtask

`ifdef ARB4_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 4'b0011; lock = 4'b0001; o_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (grant !== 4'b0001 || ack !== 4'b0001) begin
                n_err++; $display("FAIL lock_%0d: got grant %b ack %b want 0001 0001", c, grant, ack);
            end
        end
        lock = 4'b0;
        step();
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL lock_rel: got %b want 0010", grant); end
        req = 4'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; req = 4'b0; o_ready = 1'b0;
        I0 = 32'h0; I1 = 32'h1; I2 = 32'h2; I3 = 32'h3;
`ifdef ARB4_LOCK_EN
        lock = 4'b0;
`endif
        test_reset();
        test_rotation();
        test_single();
        test_backpressure();
        test_withdrawal();
        test_reset_inflight();
`ifdef ARB4_LOCK_EN
        test_lock();
`endif
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
